// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi control path: action indices and
// scheduler state encoding.
package tamagotchi_pkg;

    localparam int unsigned ACT_W   = 3;
    localparam int unsigned NUM_ACT = 5;

    localparam logic [ACT_W-1:0] ACT_SALUD     = 3'd0;
    localparam logic [ACT_W-1:0] ACT_HAMBRE    = 3'd1;
    localparam logic [ACT_W-1:0] ACT_DIVERSION = 3'd2;
    localparam logic [ACT_W-1:0] ACT_ENERGIA   = 3'd3;
    localparam logic [ACT_W-1:0] ACT_TEST      = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StCool
    } sched_state_e;

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one lane per bit.
module req_sync_edge #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;
    logic [Width-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/action_scheduler.sv
// Serializes latched stimulus requests into one valid/ack action stream with
// test-first priority, round-robin among the rest, and post-action cooldown.
module action_scheduler
    import tamagotchi_pkg::*;
#(
    parameter int unsigned COOLDOWN = 50_000_000,
    parameter int unsigned DROP_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [4:0]         req_i,
    input  logic               lcd_busy_i,
    input  logic               act_ack_i,
    output logic               act_valid_o,
    output logic [ACT_W-1:0]   act_id_o,
    output logic [NUM_ACT-1:0] pending_o,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    localparam int unsigned CntW = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CntW-1:0] CntInit = (COOLDOWN == 0) ? '0 : CntW'(COOLDOWN - 1);

    logic [NUM_ACT-1:0] rise;
    logic [NUM_ACT-1:0] pending_q, pending_d;
    logic [NUM_ACT-1:0] clr_mask;
    logic [NUM_ACT-1:0] drops;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [DROP_W+2:0]  drop_sum;
    logic [2:0]         n_drop;
    logic               ack_fire;

    sched_state_e       state_q;
    logic               act_valid_q;
    logic [ACT_W-1:0]   act_id_q;
    logic [1:0]         rr_ptr_q;
    logic [CntW-1:0]    cnt_q;

    logic [ACT_W-1:0]   win_id;
    logic [1:0]         idx;
    logic               found;

    req_sync_edge #(
        .Width (NUM_ACT)
    ) u_req_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (req_i),
        .rise_o (rise)
    );

    assign ack_fire = (state_q == StGrant) && act_ack_i;
    assign clr_mask = ack_fire ? (NUM_ACT'(1) << act_id_q) : '0;

    // A new edge on the bit being acked re-arms it rather than counting as a drop.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | rise;
        drops     = rise & pending_q & ~clr_mask;
        n_drop    = '0;
        for (int i = 0; i < NUM_ACT; i++) begin
            n_drop = n_drop + 3'(drops[i]);
        end
        drop_sum = {3'b000, drop_q} + (DROP_W + 3)'(n_drop);
        drop_d   = (drop_sum[DROP_W+2:DROP_W] != '0) ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Test request wins outright; otherwise first pending bit at or above rr_ptr.
    always_comb begin
        win_id = ACT_TEST;
        found  = 1'b0;
        idx    = '0;
        if (!pending_q[ACT_TEST]) begin
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr_q + 2'(k);
                if (!found && pending_q[idx]) begin
                    found  = 1'b1;
                    win_id = {1'b0, idx};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            act_valid_q <= 1'b0;
            act_id_q    <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!lcd_busy_i && (pending_q != '0)) begin
                        state_q     <= StGrant;
                        act_valid_q <= 1'b1;
                        act_id_q    <= win_id;
                    end
                end
                StGrant: begin
                    if (act_ack_i) begin
                        act_valid_q <= 1'b0;
                        if (act_id_q != ACT_TEST) begin
                            rr_ptr_q <= act_id_q[1:0] + 2'd1;
                        end
                        if (COOLDOWN == 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StCool;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StCool: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign act_valid_o = act_valid_q;
    assign act_id_o    = act_id_q;
    assign pending_o   = pending_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Self-checking bench for action_scheduler: table of round-robin vectors with a
// grant scoreboard, plus hand sequences for latency, cooldown, drops and reset.
module tb_action_scheduler;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic       lcd_busy;
    logic       act_ack;
    logic       act_valid;
    logic [2:0] act_id;
    logic [4:0] pending;
    logic [1:0] drop_cnt;

    logic [4:0] req2;
    logic       busy2;
    logic       ack2;
    logic       valid2;
    logic [2:0] id2;
    logic [4:0] pending2;
    logic [7:0] drop2;

    int checks;
    int errors;
    int exp_q[$];

    typedef struct {
        logic [4:0] mask;
        int         n;
        int         ids[4];
    } rr_vec_t;

    rr_vec_t vec[6];

    action_scheduler #(
        .COOLDOWN (4),
        .DROP_W   (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .lcd_busy_i  (lcd_busy),
        .act_ack_i   (act_ack),
        .act_valid_o (act_valid),
        .act_id_o    (act_id),
        .pending_o   (pending),
        .drop_cnt_o  (drop_cnt)
    );

    action_scheduler #(
        .COOLDOWN (0),
        .DROP_W   (8)
    ) dut_nocool (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req2),
        .lcd_busy_i  (busy2),
        .act_ack_i   (ack2),
        .act_valid_o (valid2),
        .act_id_o    (id2),
        .pending_o   (pending2),
        .drop_cnt_o  (drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (act_valid !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        if (act_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: act_valid %b after %0d cycles required 1", act_valid, budget);
        end
    endtask

    task automatic serve();
        int w;
        int exp_id;
        while (exp_q.size() > 0) begin
            exp_id = exp_q.pop_front();
            wait_valid(30, w);
            check("grant_id", 32'(act_id), 32'(exp_id));
            act_ack = 1'b1;
            tick();
            act_ack = 1'b0;
            check("ack_drop", 32'(act_valid), 0);
        end
    endtask

    function automatic rr_vec_t mk(input logic [4:0] m, input int n,
                                   input int a, input int b, input int c, input int d);
        rr_vec_t r;
        r.mask   = m;
        r.n      = n;
        r.ids[0] = a;
        r.ids[1] = b;
        r.ids[2] = c;
        r.ids[3] = d;
        return r;
    endfunction

    initial begin
        int  w;
        bit  seen;

        checks   = 0;
        errors   = 0;
        req      = '0;
        lcd_busy = 1'b0;
        act_ack  = 1'b0;
        req2     = '0;
        busy2    = 1'b0;
        ack2     = 1'b0;

        // rr_ptr history: 0 -> 0 -> 3 -> 3 -> 2 -> 2 -> 1
        vec[0] = mk(5'b01101, 3, 0, 2, 3, 0);
        vec[1] = mk(5'b00100, 1, 2, 0, 0, 0);
        vec[2] = mk(5'b01101, 3, 3, 0, 2, 0);
        vec[3] = mk(5'b00011, 2, 0, 1, 0, 0);
        vec[4] = mk(5'b01010, 2, 3, 1, 0, 0);
        vec[5] = mk(5'b10001, 2, 4, 0, 0, 0);

        rst_n = 1'b0;
        #3;
        check("rst_valid", 32'(act_valid), 0);
        check("rst_id", 32'(act_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            req = vec[v].mask;
            tick(2);
            req = '0;
            for (int k = 0; k < vec[v].n; k++) exp_q.push_back(vec[v].ids[k]);
            serve();
            check("rr_pend_clear", 32'(pending), 0);
        end

        // Single request latency and cooldown quiet window
        tick(6);
        req = 5'b00010;
        tick();
        check("lat_valid_t0", 32'(act_valid), 0);
        tick();
        check("lat_pend_t1", 32'(pending), 0);
        tick();
        check("lat_pend_t2", 32'(pending), 32'b00010);
        check("lat_valid_t2", 32'(act_valid), 0);
        req = '0;
        tick();
        check("lat_valid_t3", 32'(act_valid), 1);
        check("lat_id_t3", 32'(act_id), 1);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        check("single_valid_ack", 32'(act_valid), 0);
        check("single_pend_ack", 32'(pending), 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (act_valid) seen = 1'b1;
        end
        check("single_cool_quiet", 32'(seen), 0);

        // Back-to-back pending: next grant exactly COOLDOWN+1 after ack
        req = 5'b00101;
        tick(2);
        req = '0;
        wait_valid(30, w);
        check("gap_first_id", 32'(act_id), 2);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        wait_valid(30, w);
        check("gap_cycles", 32'(w), 5);
        check("gap_second_id", 32'(act_id), 0);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;

        // Test priority over requests latched during cooldown
        req = 5'b00010;
        tick(2);
        req = '0;
        wait_valid(30, w);
        check("prio_pre_id", 32'(act_id), 1);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        req = 5'b01110;
        tick();
        req = 5'b11110;
        tick(3);
        check("prio_pend", 32'(pending), 32'b11110);
        check("prio_cool_valid", 32'(act_valid), 0);
        req = '0;
        tick();
        check("prio_valid_t5", 32'(act_valid), 1);
        exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(1);
        serve();

        // Drops while LCD busy, ack ignored without valid, then set-wins on ack
        lcd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 5'b00100;
            tick();
            req = '0;
            tick();
        end
        tick(3);
        check("drop_pend", 32'(pending), 32'b00100);
        check("drop_cnt2", 32'(drop_cnt), 2);
        check("busy_no_valid", 32'(act_valid), 0);
        act_ack = 1'b1;
        tick(2);
        act_ack = 1'b0;
        check("ack_ignored", 32'(pending), 32'b00100);
        lcd_busy = 1'b0;
        wait_valid(30, w);
        check("setwin_grant_id", 32'(act_id), 2);
        req = 5'b00100;
        tick();
        lcd_busy = 1'b1;
        check("hold_valid1", 32'(act_valid), 1);
        check("hold_id1", 32'(act_id), 2);
        tick();
        check("hold_valid2", 32'(act_valid), 1);
        check("hold_id2", 32'(act_id), 2);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        req = '0;
        lcd_busy = 1'b0;
        check("setwin_valid", 32'(act_valid), 0);
        check("setwin_pend", 32'(pending), 32'b00100);
        check("setwin_drop", 32'(drop_cnt), 2);
        exp_q.push_back(2);
        serve();
        check("setwin_drained", 32'(pending), 0);

        // Reset in the middle of a grant
        req = 5'b01000;
        tick(2);
        req = '0;
        wait_valid(30, w);
        check("rstg_id", 32'(act_id), 3);
        rst_n = 1'b0;
        #1;
        check("rstg_valid", 32'(act_valid), 0);
        check("rstg_pending", 32'(pending), 0);
        check("rstg_drop", 32'(drop_cnt), 0);
        check("rstg_actid", 32'(act_id), 0);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (act_valid) seen = 1'b1;
        end
        check("rstg_no_grant", 32'(seen), 0);

        // Saturating drop counter (2 bits)
        lcd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 5'b00001;
            tick();
            req = '0;
            tick();
        end
        tick(2);
        check("sat_two", 32'(drop_cnt), 2);
        for (int i = 0; i < 3; i++) begin
            req = 5'b00001;
            tick();
            req = '0;
            tick();
        end
        tick(2);
        check("sat_five", 32'(drop_cnt), 3);
        lcd_busy = 1'b0;
        exp_q.push_back(0);
        serve();
        check("sat_pend", 32'(pending), 0);
        check("sat_hold", 32'(drop_cnt), 3);

        // Zero-cooldown instance: next grant one cycle after ack
        req2 = 5'b00011;
        tick(2);
        req2 = '0;
        w = 0;
        while (valid2 !== 1'b1 && w < 30) begin
            tick();
            w++;
        end
        check("nc_first_valid", 32'(valid2), 1);
        check("nc_first_id", 32'(id2), 0);
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        check("nc_ack_drop", 32'(valid2), 0);
        tick();
        check("nc_next_valid", 32'(valid2), 1);
        check("nc_next_id", 32'(id2), 1);
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        check("nc_pend", 32'(pending2), 0);
        check("nc_drop", 32'(drop2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
